// File: rtl/sgmii_tx_encoder_8b10b_pkg.sv
// sgmii_tx_encoder_8b10b_pkg: shared SGMII code-group constants, RD constants and 8b/10b RD- sub-block tables
package sgmii_tx_encoder_8b10b_pkg;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D21_5 = 8'hB5;
  localparam logic [7:0] D2_2 = 8'h42;
  localparam logic [7:0] D5_6 = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;
  localparam logic cRdNeg = 1'b0;
  localparam logic cRdPos = 1'b1;
  function automatic logic [5:0] enc6Neg(input logic [4:0] x);
    logic [5:0] c;
    case (x)
      5'd0: c = 6'b100111;
      5'd1: c = 6'b011101;
      5'd2: c = 6'b101101;
      5'd3: c = 6'b110001;
      5'd4: c = 6'b110101;
      5'd5: c = 6'b101001;
      5'd6: c = 6'b011001;
      5'd7: c = 6'b111000;
      5'd8: c = 6'b111001;
      5'd9: c = 6'b100101;
      5'd10: c = 6'b010101;
      5'd11: c = 6'b110100;
      5'd12: c = 6'b001101;
      5'd13: c = 6'b101100;
      5'd14: c = 6'b011100;
      5'd15: c = 6'b010111;
      5'd16: c = 6'b011011;
      5'd17: c = 6'b100011;
      5'd18: c = 6'b010011;
      5'd19: c = 6'b110010;
      5'd20: c = 6'b001011;
      5'd21: c = 6'b101010;
      5'd22: c = 6'b011010;
      5'd23: c = 6'b111010;
      5'd24: c = 6'b110011;
      5'd25: c = 6'b100110;
      5'd26: c = 6'b010110;
      5'd27: c = 6'b110110;
      5'd28: c = 6'b001110;
      5'd29: c = 6'b101110;
      5'd30: c = 6'b011110;
      default: c = 6'b101011;
    endcase
    return c;
  endfunction
  function automatic logic [3:0] enc4Neg(input logic [2:0] y, input logic k28, input logic a7);
    logic [3:0] c;
    case (y)
      3'd0: c = 4'b1011;
      3'd1: c = k28 ? 4'b0110 : 4'b1001;
      3'd2: c = k28 ? 4'b1010 : 4'b0101;
      3'd3: c = 4'b1100;
      3'd4: c = 4'b1101;
      3'd5: c = k28 ? 4'b0101 : 4'b1010;
      3'd6: c = k28 ? 4'b1001 : 4'b0110;
      default: c = a7 ? 4'b0111 : 4'b1110;
    endcase
    return c;
  endfunction
  function automatic logic isLegalK(input logic [7:0] b);
    return (b[4:0] == 5'd28) || b == K23_7 || b == K27_7 || b == K29_7 || b == K30_7;
  endfunction
endpackage

// File: rtl/sgmii_tx_encoder_8b10b_enc.sv
// sgmii_enc_5b6b_3b4b: combinational 8b/10b encode of iByte/iCtrl at running disparity iRd -> oCode (abcdei fghj, a at bit 9), oRd, oKErr
module sgmii_enc_5b6b_3b4b
  import sgmii_tx_encoder_8b10b_pkg::*;
(
  input logic [7:0] iByte,
  input logic iCtrl,
  input logic iRd,
  output logic [9:0] oCode,
  output logic oRd,
  output logic oKErr
);
  logic [4:0] x;
  logic [2:0] y;
  logic kOk, k28, rd6, a7, flip6, flip4;
  logic [5:0] s6;
  logic [3:0] s4;
  assign x = iByte[4:0];
  assign y = iByte[7:5];
  assign kOk = iCtrl && isLegalK(iByte);
  assign k28 = kOk && x == 5'd28;
  assign s6 = k28 ? 6'b001111 : enc6Neg(x);
  assign flip6 = iRd && ($countones(s6) != 3 || x == 5'd7);
  assign rd6 = iRd ^ ($countones(s6) != 3);
  assign a7 = kOk || (rd6 ? (x == 5'd11 || x == 5'd13 || x == 5'd14) : (x == 5'd17 || x == 5'd18 || x == 5'd20));
  assign s4 = enc4Neg(y, k28, a7);
  assign flip4 = rd6 && ($countones(s4) != 2 || y == 3'd3 || k28);
  assign oRd = rd6 ^ ($countones(s4) != 2);
  assign oCode = {s6 ^ {6{flip6}}, s4 ^ {4{flip4}}};
  assign oKErr = iCtrl && !kOk;
endmodule

// File: rtl/sgmii_tx_encoder_8b10b.sv
// sgmii_tx_encoder_8b10b: registered 8b/10b encoder with running disparity register, even pipeline and combinational next-RD feedback
module sgmii_tx_encoder_8b10b
  import sgmii_tx_encoder_8b10b_pkg::*;
#(
  parameter bit pRdInit = cRdNeg,
  parameter bit pLsbFirst = 1'b1
) (
  input logic i_Clk,
  input logic i_ARst_H,
  input logic [7:0] i8_TxCodeGroup,
  input logic i_TxCodeCtrl,
  input logic i_TxCodeValid,
  input logic i_TxEven,
  output logic [9:0] o10_Code,
  output logic o_CodeValid,
  output logic o_CodeEven,
  output logic o_CodeErr,
  output logic o_RunDisp,
  output logic o_RunDispNxt
);
  logic [9:0] encCode, ordCode;
  logic encRd, encErr;
  sgmii_enc_5b6b_3b4b uEnc (
    .iByte(i8_TxCodeGroup),
    .iCtrl(i_TxCodeCtrl),
    .iRd(o_RunDisp),
    .oCode(encCode),
    .oRd(encRd),
    .oKErr(encErr)
  );
  for (genvar i = 0; i < 10; i++) begin : gOrd
    assign ordCode[i] = pLsbFirst ? encCode[9 - i] : encCode[i];
  end
  assign o_RunDispNxt = i_TxCodeValid ? encRd : o_RunDisp;
  always_ff @(posedge i_Clk or posedge i_ARst_H) begin
    if (i_ARst_H) begin
      o10_Code <= '0;
      o_CodeValid <= 1'b0;
      o_CodeEven <= 1'b0;
      o_CodeErr <= 1'b0;
      o_RunDisp <= pRdInit;
    end else begin
      o_CodeValid <= i_TxCodeValid;
      o_CodeEven <= i_TxEven;
      o_CodeErr <= i_TxCodeValid && encErr;
      if (i_TxCodeValid) begin
        o10_Code <= ordCode;
        o_RunDisp <= encRd;
      end
    end
  end
endmodule

// File: tb/tb_sgmii_tx_encoder_8b10b.sv
// tb_sgmii_tx_encoder_8b10b: table-driven 8b/10b reference model, directed literal pins and a random stream compared every cycle
module tb_sgmii_tx_encoder_8b10b;
  typedef struct packed {logic [9:0] code; logic rd; logic err;} res_t;
  typedef struct packed {logic [7:0] b; logic k; logic [9:0] c; logic rd; logic err;} dir_t;
  localparam logic [5:0] T6N [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [5:0] T6P [32] = '{6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  localparam logic [3:0] D4N [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] D4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  localparam logic [3:0] K4N [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  localparam logic [3:0] K4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
  localparam logic [7:0] LEGALK [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
  localparam dir_t DIRS [13] = '{
    {8'hBC, 1'b1, 10'b0011111010, 1'b1, 1'b0},
    {8'h50, 1'b0, 10'b1001000101, 1'b0, 1'b0},
    {8'h03, 1'b0, 10'b1100011011, 1'b1, 1'b0},
    {8'hBC, 1'b1, 10'b1100000101, 1'b0, 1'b0},
    {8'hC5, 1'b0, 10'b1010010110, 1'b0, 1'b0},
    {8'hB5, 1'b0, 10'b1010101010, 1'b0, 1'b0},
    {8'h03, 1'b0, 10'b1100011011, 1'b1, 1'b0},
    {8'hB5, 1'b0, 10'b1010101010, 1'b1, 1'b0},
    {8'hF1, 1'b0, 10'b1000110001, 1'b0, 1'b0},
    {8'hF1, 1'b0, 10'b1000110111, 1'b1, 1'b0},
    {8'hEB, 1'b0, 10'b1101001000, 1'b0, 1'b0},
    {8'h00, 1'b1, 10'b1001110100, 1'b0, 1'b1},
    {8'hFB, 1'b1, 10'b1101101000, 1'b0, 1'b0}};
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] bIn = '0;
  logic kIn = 1'b0, vIn = 1'b0, eIn = 1'b0;
  logic [9:0] o10_Code;
  logic o_CodeValid, o_CodeEven, o_CodeErr, o_RunDisp, o_RunDispNxt;
  logic [9:0] mCode;
  logic mValid, mEven, mErr, mRd;
  res_t nxt;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  sgmii_tx_encoder_8b10b dut (
    .i_Clk(clk),
    .i_ARst_H(rst),
    .i8_TxCodeGroup(bIn),
    .i_TxCodeCtrl(kIn),
    .i_TxCodeValid(vIn),
    .i_TxEven(eIn),
    .o10_Code(o10_Code),
    .o_CodeValid(o_CodeValid),
    .o_CodeEven(o_CodeEven),
    .o_CodeErr(o_CodeErr),
    .o_RunDisp(o_RunDisp),
    .o_RunDispNxt(o_RunDispNxt)
  );
  function automatic logic [9:0] rev10(input logic [9:0] c);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = c[9 - i];
    return r;
  endfunction
  function automatic res_t model(input logic [7:0] b, input logic k, input logic rd);
    res_t r;
    logic [4:0] x;
    logic [2:0] y;
    logic legal, k28, rd6, a7;
    logic [5:0] s6;
    logic [3:0] s4;
    int n6, n10;
    x = b[4:0];
    y = b[7:5];
    legal = k && (b inside {8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE});
    k28 = legal && x == 5'd28;
    s6 = k28 ? (rd ? 6'b110000 : 6'b001111) : (rd ? T6P[x] : T6N[x]);
    n6 = $countones(s6);
    rd6 = n6 > 3 ? 1'b1 : n6 < 3 ? 1'b0 : rd;
    if (k28) s4 = rd6 ? K4P[y] : K4N[y];
    else if (y == 3'd7) begin
      a7 = legal || (!rd6 && x inside {5'd17, 5'd18, 5'd20}) || (rd6 && x inside {5'd11, 5'd13, 5'd14});
      s4 = a7 ? (rd6 ? 4'b1000 : 4'b0111) : (rd6 ? 4'b0001 : 4'b1110);
    end else s4 = rd6 ? D4P[y] : D4N[y];
    r.code = {s6, s4};
    n10 = $countones(r.code);
    r.rd = n10 > 5 ? 1'b1 : n10 < 5 ? 1'b0 : rd;
    r.err = k && !legal;
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  always_comb nxt = model(bIn, kIn, mRd);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mCode <= '0;
      mValid <= 1'b0;
      mEven <= 1'b0;
      mErr <= 1'b0;
      mRd <= 1'b0;
    end else begin
      mValid <= vIn;
      mEven <= eIn;
      mErr <= vIn && nxt.err;
      if (vIn) begin
        mCode <= nxt.code;
        mRd <= nxt.rd;
      end
    end
  end
  initial begin
    logic rdTrack;
    int dsp;
    rdTrack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) rdTrack = 1'b0;
      else begin
        chk("code", {22'd0, rev10(o10_Code)}, {22'd0, mCode});
        chk("valid", {31'd0, o_CodeValid}, {31'd0, mValid});
        chk("even", {31'd0, o_CodeEven}, {31'd0, mEven});
        chk("err", {31'd0, o_CodeErr}, {31'd0, mErr});
        chk("rundisp", {31'd0, o_RunDisp}, {31'd0, mRd});
        chk("rundispnxt", {31'd0, o_RunDispNxt}, {31'd0, vIn ? nxt.rd : mRd});
        if (o_CodeValid) begin
          dsp = 2 * $countones(o10_Code) - 10;
          chk("disp_range", {31'd0, dsp inside {-2, 0, 2}}, 32'd1);
          if (dsp != 0) begin
            chk("disp_alternate", {31'd0, rdTrack}, {31'd0, dsp < 0});
            rdTrack = dsp > 0;
          end
        end
      end
    end
  end
  initial begin
    int sent;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("reset_code", {22'd0, o10_Code}, 32'd0);
    chk("reset_valid", {31'd0, o_CodeValid}, 32'd0);
    chk("reset_rd", {31'd0, o_RunDisp}, 32'd0);
    chk("reset_rdnxt", {31'd0, o_RunDispNxt}, 32'd0);
    for (int i = 0; i < 13; i++) begin
      vIn = 1'b1;
      bIn = DIRS[i].b;
      kIn = DIRS[i].k;
      eIn = ~eIn;
      if (i == 0) begin
        #1 chk("k28_5_rdnxt_pre", {31'd0, o_RunDispNxt}, 32'd1);
      end
      @(posedge clk);
      #2;
      chk($sformatf("dir%0d_code", i), {22'd0, rev10(o10_Code)}, {22'd0, DIRS[i].c});
      chk($sformatf("dir%0d_model", i), {22'd0, mCode}, {22'd0, DIRS[i].c});
      chk($sformatf("dir%0d_rd", i), {31'd0, o_RunDisp}, {31'd0, DIRS[i].rd});
      chk($sformatf("dir%0d_err", i), {31'd0, o_CodeErr}, {31'd0, DIRS[i].err});
    end
    vIn = 1'b0;
    bIn = 8'h03;
    for (int i = 0; i < 3; i++) begin
      eIn = ~eIn;
      @(posedge clk);
      #2;
      chk("gap_valid", {31'd0, o_CodeValid}, 32'd0);
      chk("gap_code_hold", {22'd0, rev10(o10_Code)}, {22'd0, 10'b1101101000});
      chk("gap_rd_hold", {31'd0, o_RunDisp}, 32'd0);
      chk("gap_rdnxt", {31'd0, o_RunDispNxt}, 32'd0);
    end
    vIn = 1'b1;
    eIn = 1'b1;
    @(posedge clk);
    #2 chk("pre_reset_rd", {31'd0, o_RunDisp}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_code", {22'd0, o10_Code}, 32'd0);
    chk("async_valid", {31'd0, o_CodeValid}, 32'd0);
    chk("async_even", {31'd0, o_CodeEven}, 32'd0);
    chk("async_err", {31'd0, o_CodeErr}, 32'd0);
    chk("async_rd", {31'd0, o_RunDisp}, 32'd0);
    vIn = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    vIn = 1'b1;
    bIn = 8'hBC;
    kIn = 1'b1;
    @(posedge clk);
    #2 chk("post_reset_k28_5", {22'd0, rev10(o10_Code)}, {22'd0, 10'b0011111010});
    sent = 0;
    while (sent < 1000) begin
      vIn = $urandom_range(0, 7) != 0;
      kIn = $urandom_range(0, 3) == 0;
      bIn = (kIn && $urandom_range(0, 1) == 1) ? LEGALK[$urandom_range(0, 11)] : 8'($urandom);
      eIn = ~eIn;
      if (vIn) sent++;
      @(posedge clk);
      #2;
    end
    vIn = 1'b0;
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
